// File: rtl/dac_sample_feeder.sv
// Paces a buffered stream of 12-bit samples into the PMOD DA4 SPI master:
// one st_wrt/data_in handshake per sample tick, with done sync, timeout and recovery gap.
module dac_sample_feeder #(
    parameter int DEPTH       = 16,
    parameter int SAMPLE_DIV  = 5000,
    parameter int RECOVER_CYC = 250,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic                     clk100mhz,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     s_valid,
    input  logic [11:0]              s_data,
    output logic                     s_ready,
    output logic                     st_wrt,
    output logic [11:0]              dac_data,
    input  logic                     dac_done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     underrun,
    output logic                     overrun,
    output logic                     timeout_err,
    input  logic                     clr_err
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int DW = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
    localparam int CW = $clog2(TIMEOUT_CYC + RECOVER_CYC + 1);

    localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
    localparam logic [DW-1:0] DIV_ONE  = DW'(1);
    localparam logic [CW-1:0] TO_LAST  = CW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0] REC_LAST = CW'(RECOVER_CYC - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);
    localparam logic [LW-1:0] LVL_ONE  = LW'(1);
    localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RECOVER = 2'd2
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [DW-1:0]   div_cnt_r;
    logic [CW-1:0]   cnt_r;
    logic [AW-1:0]   wr_ptr_r, rd_ptr_r;
    logic [11:0]     mem_r [DEPTH];
    logic            sync1_r, sync2_r, sync3_r;
    logic            tick_s, push_s, pop_s, done_rise_s, full_s;
    logic            st_wrt_nxt_s, underrun_nxt_s, overrun_nxt_s, to_set_s, cnt_clr_s;

    assign tick_s      = (div_cnt_r == DIV_LAST);
    assign full_s      = (fifo_level == LVL_FULL);
    assign s_ready     = ~full_s;
    assign push_s      = s_valid & ~full_s;
    assign done_rise_s = sync2_r & ~sync3_r;

    // Sample storage; contents need no reset because pointers/level gate every read.
    always_ff @(posedge clk100mhz) begin
        if (push_s) begin
            mem_r[wr_ptr_r] <= s_data;
        end
    end

    // Next-state and per-cycle control decisions for the transfer handshake.
    always_comb begin
        state_nxt_s    = state_r;
        st_wrt_nxt_s   = 1'b0;
        pop_s          = 1'b0;
        underrun_nxt_s = 1'b0;
        overrun_nxt_s  = 1'b0;
        to_set_s       = 1'b0;
        case (state_r)
            IDLE: begin
                if (tick_s) begin
                    if (fifo_level != {LW{1'b0}}) begin
                        pop_s        = 1'b1;
                        st_wrt_nxt_s = 1'b1;
                        state_nxt_s  = BUSY;
                    end else begin
                        underrun_nxt_s = 1'b1;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            BUSY: begin
                overrun_nxt_s = tick_s;
                // done takes priority over a coincident timeout
                if (done_rise_s) begin
                    state_nxt_s = RECOVER;
                end else if (cnt_r == TO_LAST) begin
                    to_set_s    = 1'b1;
                    state_nxt_s = RECOVER;
                end else begin
                    st_wrt_nxt_s = 1'b1;
                end
            end
            RECOVER: begin
                overrun_nxt_s = tick_s;
                if (cnt_r == REC_LAST) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = RECOVER;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
        cnt_clr_s = (state_nxt_s != state_r) || (state_r == IDLE);
    end

    // State, pacing, FIFO bookkeeping, done synchronizer and registered outputs.
    always_ff @(posedge clk100mhz) begin
        if (rst) begin
            state_r     <= IDLE;
            div_cnt_r   <= {DW{1'b0}};
            cnt_r       <= {CW{1'b0}};
            wr_ptr_r    <= {AW{1'b0}};
            rd_ptr_r    <= {AW{1'b0}};
            fifo_level  <= {LW{1'b0}};
            sync1_r     <= 1'b0;
            sync2_r     <= 1'b0;
            sync3_r     <= 1'b0;
            st_wrt      <= 1'b0;
            dac_data    <= 12'h000;
            underrun    <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            sync1_r  <= dac_done;
            sync2_r  <= sync1_r;
            sync3_r  <= sync2_r;
            st_wrt   <= st_wrt_nxt_s;
            underrun <= underrun_nxt_s;
            overrun  <= overrun_nxt_s;

            if (!en || tick_s) begin
                div_cnt_r <= {DW{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DIV_ONE;
            end

            if (cnt_clr_s) begin
                cnt_r <= {CW{1'b0}};
            end else begin
                cnt_r <= cnt_r + CNT_ONE;
            end

            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
                dac_data <= mem_r[rd_ptr_r];
            end
            case ({push_s, pop_s})
                2'b10:   fifo_level <= fifo_level + LVL_ONE;
                2'b01:   fifo_level <= fifo_level - LVL_ONE;
                default: fifo_level <= fifo_level;
            endcase

            if (to_set_s) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dac_sample_feeder.sv
// Scoreboard bench for dac_sample_feeder with a behavioural DA4 master whose done delay is programmable.
module tb_dac_sample_feeder;

    localparam int DEPTH       = 16;
    localparam int SAMPLE_DIV  = 200;
    localparam int RECOVER_CYC = 25;
    localparam int TIMEOUT_CYC = 1000;
    localparam int LW          = $clog2(DEPTH) + 1;

    logic          clk100mhz = 1'b0;
    logic          rst = 1'b1;
    logic          en = 1'b0;
    logic          s_valid = 1'b0;
    logic [11:0]   s_data = 12'h000;
    logic          s_ready;
    logic          st_wrt;
    logic [11:0]   dac_data;
    logic          dac_done = 1'b0;
    logic [LW-1:0] fifo_level;
    logic          underrun, overrun, timeout_err;
    logic          clr_err = 1'b0;

    int n_cmp = 0;
    int n_err = 0;
    logic [11:0] exp_q[$];

    bit model_en = 1'b0;
    int model_delay = 10;
    int done_cnt = 0;

    dac_sample_feeder #(
        .DEPTH(DEPTH), .SAMPLE_DIV(SAMPLE_DIV),
        .RECOVER_CYC(RECOVER_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
    ) dut (
        .clk100mhz(clk100mhz), .rst(rst), .en(en), .s_valid(s_valid), .s_data(s_data),
        .s_ready(s_ready), .st_wrt(st_wrt), .dac_data(dac_data), .dac_done(dac_done),
        .fifo_level(fifo_level), .underrun(underrun), .overrun(overrun),
        .timeout_err(timeout_err), .clr_err(clr_err)
    );

    always #5 clk100mhz = ~clk100mhz;

    // DA4 stand-in: raises done model_delay cycles into a transfer, drops it once st_wrt falls.
    always @(negedge clk100mhz) begin
        if (st_wrt !== 1'b1) begin
            done_cnt = 0;
            dac_done = 1'b0;
        end else begin
            done_cnt = done_cnt + 1;
            if (model_en && done_cnt >= model_delay) dac_done = 1'b1;
        end
    end

    task automatic do_reset();
        @(negedge clk100mhz);
        rst = 1'b1; en = 1'b0; s_valid = 1'b0; clr_err = 1'b0;
        repeat (3) @(negedge clk100mhz);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic push_sample(input logic [11:0] d);
        @(negedge clk100mhz);
        s_valid = 1'b1; s_data = d;
        exp_q.push_back(d);
        @(negedge clk100mhz);
        s_valid = 1'b0;
    endtask

    // Bounded wait for st_wrt to reach a level, counting flag pulses on the way.
    task automatic wait_st(input logic want, input int budget, output int cyc,
                           output int ovr, output int unr, output bit ok);
        cyc = 0; ovr = 0; unr = 0; ok = 1'b0;
        while (cyc < budget) begin
            @(negedge clk100mhz);
            cyc++;
            if (overrun === 1'b1) ovr++;
            if (underrun === 1'b1) unr++;
            if (st_wrt === want) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp += 7;
        if (st_wrt !== 1'b0)          begin n_err++; $display("FAIL reset_st_wrt got %b want 0", st_wrt); end
        if (s_ready !== 1'b1)         begin n_err++; $display("FAIL reset_s_ready got %b want 1", s_ready); end
        if (fifo_level !== '0)        begin n_err++; $display("FAIL reset_level got %0d want 0", fifo_level); end
        if (dac_data !== 12'h000)     begin n_err++; $display("FAIL reset_dac_data got %h want 000", dac_data); end
        if (underrun !== 1'b0)        begin n_err++; $display("FAIL reset_underrun got %b want 0", underrun); end
        if (overrun !== 1'b0)         begin n_err++; $display("FAIL reset_overrun got %b want 0", overrun); end
        if (timeout_err !== 1'b0)     begin n_err++; $display("FAIL reset_timeout got %b want 0", timeout_err); end
    endtask

    task automatic test_two_transfers();
        int c1, c2, o, u;
        bit ok;
        logic [11:0] e;
        do_reset();
        model_en = 1'b1; model_delay = 20;
        push_sample(12'h123);
        push_sample(12'hABC);
        n_cmp++;
        if (fifo_level !== LW'(2)) begin n_err++; $display("FAIL xfer_level got %0d want 2", fifo_level); end
        en = 1'b1;
        wait_st(1'b1, 2 * SAMPLE_DIV, c1, o, u, ok);
        for (int i = 0; i < 2; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            n_cmp += 2;
            if (!ok)           begin n_err++; $display("FAIL xfer%0d_rise_wait expired", i); end
            if (dac_data !== e) begin n_err++; $display("FAIL xfer%0d_data got %h want %h", i, dac_data, e); end
            wait_st(1'b0, 4 * model_delay, c1, o, u, ok);
            n_cmp++;
            if (c1 != model_delay + 2) begin n_err++; $display("FAIL xfer%0d_high_len got %0d want %0d", i, c1, model_delay + 2); end
            if (i == 0) begin
                wait_st(1'b1, 2 * SAMPLE_DIV, c2, o, u, ok);
                n_cmp++;
                if (c1 + c2 != SAMPLE_DIV) begin n_err++; $display("FAIL xfer_period got %0d want %0d", c1 + c2, SAMPLE_DIV); end
            end
        end
        n_cmp += 2;
        if (fifo_level !== '0)    begin n_err++; $display("FAIL xfer_level_end got %0d want 0", fifo_level); end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL xfer_timeout got %b want 0", timeout_err); end
    endtask

    task automatic test_fifo_full();
        int c, o, u;
        bit ok;
        logic [11:0] e;
        do_reset();
        model_en = 1'b1; model_delay = 10;
        for (int i = 0; i <= DEPTH; i++) begin
            @(negedge clk100mhz);
            s_valid = 1'b1; s_data = 12'h100 + 12'(i);
            n_cmp++;
            if (s_ready !== (i < DEPTH)) begin n_err++; $display("FAIL full_ready%0d got %b want %b", i, s_ready, i < DEPTH); end
            if (i < DEPTH) exp_q.push_back(12'h100 + 12'(i));
        end
        @(negedge clk100mhz);
        s_valid = 1'b0;
        n_cmp += 2;
        if (fifo_level !== LW'(DEPTH)) begin n_err++; $display("FAIL full_level got %0d want %0d", fifo_level, DEPTH); end
        if (s_ready !== 1'b0)          begin n_err++; $display("FAIL full_s_ready got %b want 0", s_ready); end
        en = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            wait_st(1'b1, 2 * SAMPLE_DIV, c, o, u, ok);
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            n_cmp++;
            if (!ok || dac_data !== e) begin n_err++; $display("FAIL drain%0d_data got %h want %h ok=%0d", i, dac_data, e, ok); end
            wait_st(1'b0, 4 * model_delay, c, o, u, ok);
        end
        // the 17th sample must not appear: the next tick only underruns
        wait_st(1'b1, SAMPLE_DIV + 5, c, o, u, ok);
        n_cmp += 2;
        if (ok)     begin n_err++; $display("FAIL full_extra_xfer got rise want none"); end
        if (u != 1) begin n_err++; $display("FAIL full_underrun got %0d want 1", u); end
    endtask

    task automatic test_underrun();
        int first, cnt;
        bit seen;
        do_reset();
        first = 0; cnt = 0; seen = 1'b0;
        @(negedge clk100mhz);
        en = 1'b1;
        for (int k = 1; k <= 3 * SAMPLE_DIV; k++) begin
            @(negedge clk100mhz);
            if (underrun === 1'b1) begin
                cnt++;
                if (first == 0) first = k;
            end
            if (st_wrt !== 1'b0) seen = 1'b1;
        end
        n_cmp += 3;
        if (first != SAMPLE_DIV) begin n_err++; $display("FAIL under_first got %0d want %0d", first, SAMPLE_DIV); end
        if (cnt != 3)            begin n_err++; $display("FAIL under_count got %0d want 3", cnt); end
        if (seen)                begin n_err++; $display("FAIL under_st_wrt got 1 want 0"); end
    endtask

    task automatic test_timeout();
        int c, o, u;
        bit ok;
        do_reset();
        model_en = 1'b0;
        push_sample(12'h777);
        en = 1'b1;
        wait_st(1'b1, 2 * SAMPLE_DIV, c, o, u, ok);
        wait_st(1'b0, TIMEOUT_CYC + 10, c, o, u, ok);
        en = 1'b0;
        n_cmp += 3;
        if (!ok)                  begin n_err++; $display("FAIL to_fall_wait expired"); end
        if (c != TIMEOUT_CYC)     begin n_err++; $display("FAIL to_busy_len got %0d want %0d", c, TIMEOUT_CYC); end
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err_set got %b want 1", timeout_err); end
        repeat (10) @(negedge clk100mhz);
        n_cmp++;
        if (timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err_sticky got %b want 1", timeout_err); end
        clr_err = 1'b1;
        @(negedge clk100mhz);
        clr_err = 1'b0;
        n_cmp++;
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL to_err_clr got %b want 0", timeout_err); end
        // done landing on the final timeout cycle wins: no error
        do_reset();
        model_en = 1'b1; model_delay = TIMEOUT_CYC - 2;
        push_sample(12'h3C3);
        en = 1'b1;
        wait_st(1'b1, 2 * SAMPLE_DIV, c, o, u, ok);
        wait_st(1'b0, TIMEOUT_CYC + 10, c, o, u, ok);
        n_cmp += 2;
        if (c != TIMEOUT_CYC)     begin n_err++; $display("FAIL tie_busy_len got %0d want %0d", c, TIMEOUT_CYC); end
        if (timeout_err !== 1'b0) begin n_err++; $display("FAIL tie_err got %b want 0", timeout_err); end
    endtask

    task automatic test_overrun();
        int c1, c2, o1, o2, u;
        bit ok;
        logic [11:0] e;
        do_reset();
        model_en = 1'b1; model_delay = 2 * SAMPLE_DIV;
        push_sample(12'hA01);
        push_sample(12'hA02);
        push_sample(12'hA03);
        en = 1'b1;
        wait_st(1'b1, 2 * SAMPLE_DIV, c1, o1, u, ok);
        for (int i = 0; i < 3; i++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
            n_cmp++;
            if (!ok || dac_data !== e) begin n_err++; $display("FAIL ovr%0d_data got %h want %h ok=%0d", i, dac_data, e, ok); end
            if (i < 2) begin
                wait_st(1'b0, 4 * SAMPLE_DIV, c1, o1, u, ok);
                wait_st(1'b1, 4 * SAMPLE_DIV, c2, o2, u, ok);
                n_cmp += 2;
                if (c1 + c2 != 3 * SAMPLE_DIV) begin n_err++; $display("FAIL ovr%0d_period got %0d want %0d", i, c1 + c2, 3 * SAMPLE_DIV); end
                if (o1 + o2 != 2)              begin n_err++; $display("FAIL ovr%0d_pulses got %0d want 2", i, o1 + o2); end
            end
        end
        n_cmp++;
        if (fifo_level !== '0) begin n_err++; $display("FAIL ovr_level got %0d want 0", fifo_level); end
    endtask

    task automatic test_recover_gap();
        int c1, c2, o1, o2, u;
        bit ok;
        do_reset();
        // done timed so the following tick lands inside the recovery gap
        model_en = 1'b1; model_delay = SAMPLE_DIV - 2 - RECOVER_CYC / 2;
        push_sample(12'h0F0);
        push_sample(12'h0F1);
        en = 1'b1;
        wait_st(1'b1, 2 * SAMPLE_DIV, c1, o1, u, ok);
        wait_st(1'b0, 2 * SAMPLE_DIV, c1, o1, u, ok);
        wait_st(1'b1, 3 * SAMPLE_DIV, c2, o2, u, ok);
        n_cmp += 3;
        if (c1 + c2 != 2 * SAMPLE_DIV) begin n_err++; $display("FAIL rec_period got %0d want %0d", c1 + c2, 2 * SAMPLE_DIV); end
        if (o1 + o2 != 1)              begin n_err++; $display("FAIL rec_overrun got %0d want 1", o1 + o2); end
        if (dac_data !== 12'h0F1)      begin n_err++; $display("FAIL rec_data got %h want 0f1", dac_data); end
    endtask

    task automatic test_reset_mid_busy();
        int c, o, u;
        bit ok;
        logic [11:0] e;
        do_reset();
        model_en = 1'b0;
        push_sample(12'h456);
        push_sample(12'h789);
        en = 1'b1;
        wait_st(1'b1, 2 * SAMPLE_DIV, c, o, u, ok);
        repeat (10) @(negedge clk100mhz);
        rst = 1'b1;
        @(negedge clk100mhz);
        n_cmp += 5;
        if (st_wrt !== 1'b0)      begin n_err++; $display("FAIL rstb_st_wrt got %b want 0", st_wrt); end
        if (fifo_level !== '0)    begin n_err++; $display("FAIL rstb_level got %0d want 0", fifo_level); end
        if (s_ready !== 1'b1)     begin n_err++; $display("FAIL rstb_s_ready got %b want 1", s_ready); end
        if (dac_data !== 12'h000) begin n_err++; $display("FAIL rstb_dac_data got %h want 000", dac_data); end
        if ({underrun, overrun, timeout_err} !== 3'b000) begin n_err++; $display("FAIL rstb_flags got %b want 000", {underrun, overrun, timeout_err}); end
        rst = 1'b0;
        exp_q.delete();
        model_en = 1'b1; model_delay = 10;
        push_sample(12'h5A5);
        wait_st(1'b1, 2 * SAMPLE_DIV, c, o, u, ok);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        n_cmp++;
        if (!ok || dac_data !== e) begin n_err++; $display("FAIL rstb_after_data got %h want %h ok=%0d", dac_data, e, ok); end
        wait_st(1'b0, 4 * model_delay, c, o, u, ok);
    endtask

    initial begin
        test_reset();
        test_two_transfers();
        test_fifo_full();
        test_underrun();
        test_timeout();
        test_overrun();
        test_recover_gap();
        test_reset_mid_busy();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
